uart_boot_loader: RTL and testbench

Consumes the byte stream from the UART receiver and writes a length-prefixed program image into word-addressed instruction memory. Holds the core in reset while loading, checks an XOR checksum, then releases the core (or flags an error). Sits between the UART receiver and the instruction-memory write port.

---
 rtl/boot_pkg.sv | 13 +
 rtl/edge_rise.sv | 19 +
 rtl/uart_boot_loader.sv | 128 ++++++++++++
 tb/tb_uart_boot_loader.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot loader.
package boot_pkg;
    typedef enum logic [2:0] {
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam int HDR_BYTES = 4;
    localparam int WORD_W    = 32;
endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector: one strobe per low-to-high transition of a level.
// The previous level is registered; the strobe itself is combinational so
// the consumer acts on the very edge where the level is first seen high.
module edge_rise (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic level_i,
    output logic rise_o
);
    logic rdy_q;

    // Remember last cycle's level; resets low so a level high out of reset counts
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rdy_q <= 1'b0;
        else         rdy_q <= level_i;
    end

    assign rise_o = level_i & ~rdy_q;
endmodule

// File: rtl/uart_boot_loader.sv
// Boot loader: parses a length-prefixed, XOR-checksummed image from the UART
// byte stream, writes it word by word into instruction memory, and releases
// the core only after the checksum matches.
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [7:0]        byte_i,
    input  logic              byte_ready_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              cpu_hold_o,
    output logic              done_o,
    output logic              err_o
);
    state_t            state_q;
    logic [1:0]        byte_cnt_q;
    logic [23:0]       shift_q;     // lanes 0..2; lane 3 comes straight from byte_i
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W-1:0] word_q;
    logic [7:0]        csum_q;

    logic              w_acc;
    logic              w_lane3;
    logic [WORD_W-1:0] w_word;
    logic              w_len_ovf;
    logic [ADDR_W:0]   w_word_nxt;
    logic              w_last_word;
    logic              w_collect;

    edge_rise u_edge (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .level_i (byte_ready_i),
        .rise_o  (w_acc)
    );

    assign w_lane3     = (byte_cnt_q == 2'(HDR_BYTES - 1));
    assign w_word      = {byte_i, shift_q};
    // Legal lengths are 0..2^ADDR_W inclusive
    assign w_len_ovf   = (|w_word[WORD_W-1:ADDR_W+1]) |
                         (w_word[ADDR_W] & (|w_word[ADDR_W-1:0]));
    assign w_word_nxt  = {1'b0, word_q} + 1'b1;
    assign w_last_word = (w_word_nxt == len_q);
    assign w_collect   = (state_q == ST_LEN) || (state_q == ST_DATA);

    // Frame FSM with registered status outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_LEN;
            cpu_hold_o <= 1'b1;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
        end else if (w_acc) begin
            case (state_q)
                ST_LEN: if (w_lane3) begin
                    if (w_len_ovf) begin
                        state_q <= ST_ERR;
                        err_o   <= 1'b1;
                    end else if (w_word[ADDR_W:0] == '0) begin
                        state_q <= ST_CSUM;
                    end else begin
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: if (w_lane3 && w_last_word) state_q <= ST_CSUM;
                ST_CSUM: begin
                    if ((csum_q ^ byte_i) == 8'h00) begin
                        state_q    <= ST_DONE;
                        done_o     <= 1'b1;
                        cpu_hold_o <= 1'b0;
                    end else begin
                        state_q <= ST_ERR;
                        err_o   <= 1'b1;
                    end
                end
                default: ;  // DONE and ERR hold until reset
            endcase
        end
    end

    // Byte lane counter, lane assembly, length latch and word address
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            byte_cnt_q <= '0;
            shift_q    <= '0;
            len_q      <= '0;
            word_q     <= '0;
        end else if (w_acc && w_collect) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            case (byte_cnt_q)
                2'd0:    shift_q[7:0]   <= byte_i;
                2'd1:    shift_q[15:8]  <= byte_i;
                2'd2:    shift_q[23:16] <= byte_i;
                default: ;
            endcase
            if (state_q == ST_LEN && w_lane3) len_q <= w_word[ADDR_W:0];
            // Stop at the last word so the address never wraps when L = 2^ADDR_W
            if (state_q == ST_DATA && w_lane3 && !w_last_word) word_q <= word_q + 1'b1;
        end
    end

    // Running XOR over every accepted byte
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)    csum_q <= '0;
        else if (w_acc) csum_q <= csum_q ^ byte_i;
    end

    // Memory write port: single-cycle strobe, address/data held between writes
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            mem_we_o <= 1'b0;
            if (w_acc && state_q == ST_DATA && w_lane3) begin
                mem_we_o    <= 1'b1;
                mem_addr_o  <= word_q;
                mem_wdata_o <= w_word;
            end
        end
    end
endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader (ADDR_W=4 so length limits are reachable).
module tb_uart_boot_loader;
    localparam int AW = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    byte_in = 8'h00;
    logic          byte_rdy = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold, done, err;

    int total = 0;
    int bad   = 0;
    wr_t exp_q[$];
    logic [31:0] img[$];

    uart_boot_loader #(.ADDR_W(AW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .byte_i       (byte_in),
        .byte_ready_i (byte_rdy),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .cpu_hold_o   (cpu_hold),
        .done_o       (done),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    // Write monitor: every strobe must match the head of the expected queue
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL wr_unexpected got addr=%0h data=%h, required no write", mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data) begin
                    bad++;
                    $display("FAIL wr_data got addr=%0h data=%h, required addr=%0h data=%h",
                             mem_addr, mem_wdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(posedge clk); #1;
        byte_in  = b;
        byte_rdy = 1'b1;
        repeat (hold) @(posedge clk);
        #1 byte_rdy = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        byte_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we",   {31'd0, mem_we},   32'd0);
        chk("rst_addr", {28'd0, mem_addr}, 32'd0);
        chk("rst_data", mem_wdata,         32'd0);
        chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rst_done", {31'd0, done},     32'd0);
        chk("rst_err",  {31'd0, err},      32'd0);
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    // Sends header, img[0..L-1] and checksum (xored with cx to corrupt it).
    // Only the first nbytes_max bytes are sent (for mid-frame reset).
    task automatic send_frame(input logic [31:0] L, input logic [7:0] cx, input int hold,
                              input bit push_wr, input int nbytes_max);
        logic [7:0] c;
        logic [7:0] bytes[$];
        c = 8'h00;
        for (int k = 0; k < 4; k++) bytes.push_back(L[8*k +: 8]);
        for (int i = 0; i < int'(L); i++) begin
            logic [31:0] w;
            w = img[i];
            for (int k = 0; k < 4; k++) bytes.push_back(w[8*k +: 8]);
        end
        foreach (bytes[i]) c ^= bytes[i];
        bytes.push_back(c ^ cx);
        for (int i = 0; i < bytes.size() && i < nbytes_max; i++) begin
            if (push_wr && i >= 4 && i < bytes.size() - 1 && ((i - 4) % 4) == 3) begin
                wr_t e;
                e.addr = AW'((i - 4) / 4);
                e.data = img[(i - 4) / 4];
                exp_q.push_back(e);
            end
            send_byte(bytes[i], hold);
        end
    endtask

    task automatic chk_status(input string tag, input bit d, input bit e, input bit h);
        chk({tag, "_done"}, {31'd0, done},     {31'd0, d});
        chk({tag, "_err"},  {31'd0, err},      {31'd0, e});
        chk({tag, "_hold"}, {31'd0, cpu_hold}, {31'd0, h});
        chk({tag, "_drain"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        do_reset();

        // L=1, 0xDEADBEEF: bytes 01 00 00 00 EF BE AD DE, checksum 0x23
        img = '{32'hDEADBEEF};
        send_frame(32'd1, 8'h00, 1, 1'b1, 100);
        chk_status("l1", 1'b1, 1'b0, 1'b0);

        // L=2, 0x00000013 / 0x00100093, checksum 0x92
        do_reset();
        img = '{32'h00000013, 32'h00100093};
        send_frame(32'd2, 8'h00, 1, 1'b1, 100);
        chk_status("l2", 1'b1, 1'b0, 1'b0);

        // Same image, checksum 0x93: writes happen, then error; trailing bytes ignored
        do_reset();
        send_frame(32'd2, 8'h01, 1, 1'b1, 100);
        chk_status("bad_c", 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) send_byte(8'h55 + 8'(i), 1);
        chk_status("bad_tail", 1'b0, 1'b1, 1'b1);

        // L=0x11 > 16 words: error after header, no writes even with more bytes
        do_reset();
        send_byte(8'h11, 1); send_byte(8'h00, 1); send_byte(8'h00, 1);
        chk("ovf_pre_err", {31'd0, err}, 32'd0);
        send_byte(8'h00, 1);
        chk_status("ovf", 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) send_byte(8'hA0 + 8'(i), 1);
        chk_status("ovf_tail", 1'b0, 1'b1, 1'b1);

        // Upper-byte overflow: L=0x01000001
        do_reset();
        send_byte(8'h01, 1); send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h01, 1);
        chk_status("ovf_hi", 1'b0, 1'b1, 1'b1);

        // L=0x10: full memory, addresses 0..15
        do_reset();
        img.delete();
        for (int i = 0; i < 16; i++) img.push_back(32'h1000_0000 + 32'(i) * 32'h0101_0101);
        send_frame(32'h10, 8'h00, 1, 1'b1, 1000);
        chk_status("l16", 1'b1, 1'b0, 1'b0);

        // L=0, C=0x00: done with no writes
        do_reset();
        send_frame(32'd0, 8'h00, 1, 1'b0, 100);
        chk_status("l0", 1'b1, 1'b0, 1'b0);

        // Level held 700 cycles per byte: each byte accepted once
        do_reset();
        img = '{32'hDEADBEEF};
        send_frame(32'd1, 8'h00, 700, 1'b1, 100);
        chk_status("hold700", 1'b1, 1'b0, 1'b0);

        // Reset after 6 of 13 bytes, then the full L=2 frame
        do_reset();
        img = '{32'h00000013, 32'h00100093};
        send_frame(32'd2, 8'h00, 1, 1'b0, 6);
        chk_status("part", 1'b0, 1'b0, 1'b1);
        do_reset();
        send_frame(32'd2, 8'h00, 1, 1'b1, 100);
        chk_status("resend", 1'b1, 1'b0, 1'b0);

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
